// File: rtl/lieat_ifu_ibuf_pkg.sv
// lieat_ifu_ibuf_pkg: shared IFU defines for the fetch-response buffer.
package lieat_ifu_ibuf_pkg;
    localparam int XLEN = 32;
    localparam int IBUF_DEPTH = 2;
    localparam logic [XLEN-1:0] PC_DEFAULT = 32'h8000_0000;
    typedef enum logic [1:0] {
        ENT_EMPTY = 2'd0,
        ENT_PEND  = 2'd1,
        ENT_VALID = 2'd2
    } ent_state_e;
endpackage

// File: rtl/lieat_ifu_ibuf_entry.sv
// lieat_ifu_ibuf_entry: one buffer slot holding state, pc, instruction and fault.
module lieat_ifu_ibuf_entry
    import lieat_ifu_ibuf_pkg::*;
#(
    parameter int XLEN = lieat_ifu_ibuf_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_inst,
    input  logic            fill_fault,
    input  logic            free,
    output ent_state_e      state,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] inst,
    output logic            fault
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ENT_EMPTY;
            pc    <= '0;
            inst  <= '0;
            fault <= 1'b0;
        end else begin
            state <= clear ? ENT_EMPTY : alloc ? ENT_PEND : fill ? ENT_VALID : free ? ENT_EMPTY : state;
            if (alloc) pc <= alloc_pc;
            if (fill) begin
                inst  <= fill_inst;
                fault <= fill_fault;
            end
        end
    end
endmodule

// File: rtl/lieat_ifu_ibuf.sv
// lieat_ifu_ibuf: issues fetches, buffers in-order responses for decode, drops flushed responses.
module lieat_ifu_ibuf
    import lieat_ifu_ibuf_pkg::*;
#(
    parameter int XLEN  = lieat_ifu_ibuf_pkg::XLEN,
    parameter int DEPTH = IBUF_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_req,
    input  logic [XLEN-1:0] ifetch_pc,
    output logic            ifetch_req,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            ibuf_valid,
    input  logic            ibuf_ready,
    output logic [XLEN-1:0] ibuf_pc,
    output logic [XLEN-1:0] ibuf_inst,
    output logic            ibuf_fault
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] alloc_ptr, fill_ptr, head_ptr;
    logic [CW-1:0] drop_cnt, drop_nxt, drop_base, occ_cnt, pend_cnt;
    ent_state_e    e_state [DEPTH];
    logic [XLEN-1:0] e_pc [DEPTH];
    logic [XLEN-1:0] e_inst [DEPTH];
    logic          e_fault [DEPTH];
    logic          credit_ok, fire, fill_en, deq;

    always_comb begin
        occ_cnt  = '0;
        pend_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_cnt  += CW'(e_state[i] != ENT_EMPTY);
            pend_cnt += CW'(e_state[i] == ENT_PEND);
        end
    end

    // Entries in use plus responses still owed to a dead stream bound outstanding requests.
    assign credit_ok     = (CW+1)'(occ_cnt) + (CW+1)'(drop_cnt) < (CW+1)'(DEPTH);
    assign mem_req_valid = rst_n & credit_ok & ~flush_req;
    assign fire          = mem_req_valid & mem_req_ready;
    assign ifetch_req    = fire;
    assign mem_req_addr  = ifetch_pc;
    assign fill_en       = mem_rsp_valid & ~flush_req & (drop_cnt == '0) & (e_state[fill_ptr] == ENT_PEND);
    assign ibuf_valid    = e_state[head_ptr] == ENT_VALID;
    assign deq           = ibuf_valid & ibuf_ready & ~flush_req;
    assign ibuf_pc       = e_pc[head_ptr];
    assign ibuf_inst     = e_inst[head_ptr];
    assign ibuf_fault    = e_fault[head_ptr];

    // A response arriving on the flush cycle belongs to the old stream.
    always_comb begin
        drop_base = flush_req ? drop_cnt + pend_cnt : drop_cnt;
        drop_nxt  = drop_base - CW'(mem_rsp_valid && drop_base != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            drop_cnt  <= '0;
        end else begin
            alloc_ptr <= flush_req ? '0 : alloc_ptr + PW'(fire);
            fill_ptr  <= flush_req ? '0 : fill_ptr + PW'(fill_en);
            head_ptr  <= flush_req ? '0 : head_ptr + PW'(deq);
            drop_cnt  <= drop_nxt;
        end
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        lieat_ifu_ibuf_entry #(.XLEN(XLEN)) u_entry (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (flush_req),
            .alloc      (fire && alloc_ptr == PW'(e)),
            .alloc_pc   (ifetch_pc),
            .fill       (fill_en && fill_ptr == PW'(e)),
            .fill_inst  (mem_rsp_data),
            .fill_fault (mem_rsp_err),
            .free       (deq && head_ptr == PW'(e)),
            .state      (e_state[e]),
            .pc         (e_pc[e]),
            .inst       (e_inst[e]),
            .fault      (e_fault[e])
        );
    end

    a_rsp_owed: assert property (@(posedge clk) disable iff (!rst_n)
        mem_rsp_valid |-> (drop_cnt != '0 || pend_cnt != '0));
endmodule

// File: tb/tb_lieat_ifu_ibuf.sv
// tb_lieat_ifu_ibuf: directed checks of issue, ordering, backpressure, flush drop and reset.
module tb_lieat_ifu_ibuf;
    import lieat_ifu_ibuf_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush_req = 1'b0;
    logic [31:0] ifetch_pc = '0;
    logic        ifetch_req;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        mem_rsp_err = 1'b0;
    logic        ibuf_valid;
    logic        ibuf_ready = 1'b0;
    logic [31:0] ibuf_pc;
    logic [31:0] ibuf_inst;
    logic        ibuf_fault;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lieat_ifu_ibuf #(.XLEN(32), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .ifetch_pc(ifetch_pc),
        .ifetch_req(ifetch_req), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_err(mem_rsp_err), .ibuf_valid(ibuf_valid), .ibuf_ready(ibuf_ready),
        .ibuf_pc(ibuf_pc), .ibuf_inst(ibuf_inst), .ibuf_fault(ibuf_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc);
        ifetch_pc = pc;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input logic err);
        mem_rsp_valid = 1'b1;
        mem_rsp_data = data;
        mem_rsp_err = err;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_err = 1'b0;
    endtask

    task automatic dequeue();
        ibuf_ready = 1'b1;
        tick();
        ibuf_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        ifetch_pc = PC_DEFAULT;
        mem_req_ready = 1'b1;
        #1;
        checks++; if (ibuf_valid !== 1'b0) begin failures++; $display("FAIL rst_ibuf_valid got=%0h exp=0", ibuf_valid); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_mem_req_valid got=%0h exp=0", mem_req_valid); end
        checks++; if (ifetch_req !== 1'b0) begin failures++; $display("FAIL rst_ifetch_req got=%0h exp=0", ifetch_req); end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL rel_mem_req_valid got=%0h exp=1", mem_req_valid); end
        checks++; if (ifetch_req !== 1'b1) begin failures++; $display("FAIL rel_ifetch_req got=%0h exp=1", ifetch_req); end
        checks++; if (mem_req_addr !== 32'h8000_0000) begin failures++; $display("FAIL rel_addr got=%h exp=80000000", mem_req_addr); end
        mem_req_ready = 1'b0;
        #1;
    endtask

    task automatic test_in_order();
        ifetch_pc = 32'h100;
        mem_req_ready = 1'b1;
        #1;
        checks++; if (mem_req_addr !== 32'h100) begin failures++; $display("FAIL ord_addr got=%h exp=00000100", mem_req_addr); end
        tick();
        ifetch_pc = 32'h104;
        #1;
        checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL ord_second_req got=%0h exp=1", mem_req_valid); end
        tick();
        mem_req_ready = 1'b0;
        #1;
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL ord_full_req got=%0h exp=0", mem_req_valid); end
        mem_rsp_valid = 1'b1;
        mem_rsp_data = 32'h0000_0013;
        #1;
        checks++; if (ibuf_valid !== 1'b0) begin failures++; $display("FAIL ord_latency got=%0h exp=0", ibuf_valid); end
        tick();
        mem_rsp_data = 32'h0010_0093;
        ibuf_ready = 1'b1;
        #1;
        checks++; if (ibuf_valid !== 1'b1 || ibuf_pc !== 32'h100 || ibuf_inst !== 32'h13) begin
            failures++; $display("FAIL ord_first got=%0h/%h/%h exp=1/00000100/00000013", ibuf_valid, ibuf_pc, ibuf_inst); end
        tick();
        mem_rsp_valid = 1'b0;
        #1;
        checks++; if (ibuf_valid !== 1'b1 || ibuf_pc !== 32'h104 || ibuf_inst !== 32'h0010_0093 || ibuf_fault !== 1'b0) begin
            failures++; $display("FAIL ord_second got=%0h/%h/%h/%0h exp=1/00000104/00100093/0", ibuf_valid, ibuf_pc, ibuf_inst, ibuf_fault); end
        tick();
        ibuf_ready = 1'b0;
        #1;
        checks++; if (ibuf_valid !== 1'b0) begin failures++; $display("FAIL ord_drained got=%0h exp=0", ibuf_valid); end
    endtask

    task automatic test_backpressure();
        issue(32'h110);
        issue(32'h114);
        respond(32'hA, 1'b0);
        respond(32'hB, 1'b0);
        #1;
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL bp_full_req got=%0h exp=0", mem_req_valid); end
        checks++; if (ibuf_valid !== 1'b1 || ibuf_pc !== 32'h110) begin failures++; $display("FAIL bp_head got=%0h/%h exp=1/00000110", ibuf_valid, ibuf_pc); end
        dequeue();
        #1;
        checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL bp_credit_back got=%0h exp=1", mem_req_valid); end
        checks++; if (ibuf_pc !== 32'h114 || ibuf_inst !== 32'hB) begin failures++; $display("FAIL bp_second got=%h/%h exp=00000114/0000000b", ibuf_pc, ibuf_inst); end
        dequeue();
    endtask

    task automatic test_flush_no_rsp();
        issue(32'h200);
        issue(32'h204);
        flush_req = 1'b1;
        mem_req_ready = 1'b1;
        ifetch_pc = 32'h208;
        #1;
        checks++; if (mem_req_valid !== 1'b0 || ifetch_req !== 1'b0) begin failures++; $display("FAIL fl_no_issue got=%0h/%0h exp=0/0", mem_req_valid, ifetch_req); end
        tick();
        flush_req = 1'b0;
        mem_req_ready = 1'b0;
        #1;
        checks++; if (dut.drop_cnt !== 3'd2) begin failures++; $display("FAIL fl_drop2 got=%0d exp=2", dut.drop_cnt); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL fl_no_credit got=%0h exp=0", mem_req_valid); end
        respond(32'hDEAD, 1'b0);
        #1;
        checks++; if (ibuf_valid !== 1'b0 || dut.drop_cnt !== 3'd1) begin failures++; $display("FAIL fl_drop_first got=%0h/%0d exp=0/1", ibuf_valid, dut.drop_cnt); end
        respond(32'hBEEF, 1'b0);
        #1;
        checks++; if (ibuf_valid !== 1'b0 || dut.drop_cnt !== 3'd0 || mem_req_valid !== 1'b1) begin
            failures++; $display("FAIL fl_drop_second got=%0h/%0d/%0h exp=0/0/1", ibuf_valid, dut.drop_cnt, mem_req_valid); end
        issue(32'h300);
        respond(32'h33, 1'b0);
        #1;
        checks++; if (ibuf_valid !== 1'b1 || ibuf_pc !== 32'h300 || ibuf_inst !== 32'h33) begin
            failures++; $display("FAIL fl_new_stream got=%0h/%h/%h exp=1/00000300/00000033", ibuf_valid, ibuf_pc, ibuf_inst); end
        dequeue();
    endtask

    task automatic test_flush_with_rsp();
        issue(32'h200);
        issue(32'h204);
        flush_req = 1'b1;
        respond(32'h77, 1'b0);
        flush_req = 1'b0;
        #1;
        checks++; if (dut.drop_cnt !== 3'd1 || ibuf_valid !== 1'b0) begin failures++; $display("FAIL fr_drop1 got=%0d/%0h exp=1/0", dut.drop_cnt, ibuf_valid); end
        respond(32'h88, 1'b0);
        #1;
        checks++; if (dut.drop_cnt !== 3'd0 || ibuf_valid !== 1'b0) begin failures++; $display("FAIL fr_dropped got=%0d/%0h exp=0/0", dut.drop_cnt, ibuf_valid); end
        issue(32'h208);
        respond(32'h55, 1'b0);
        #1;
        checks++; if (ibuf_valid !== 1'b1 || ibuf_pc !== 32'h208 || ibuf_inst !== 32'h55) begin
            failures++; $display("FAIL fr_new_stream got=%0h/%h/%h exp=1/00000208/00000055", ibuf_valid, ibuf_pc, ibuf_inst); end
        dequeue();
    endtask

    task automatic test_fault_reset();
        issue(32'h400);
        respond(32'hBAD, 1'b1);
        #1;
        checks++; if (ibuf_valid !== 1'b1 || ibuf_fault !== 1'b1 || ibuf_pc !== 32'h400) begin
            failures++; $display("FAIL flt_head got=%0h/%0h/%h exp=1/1/00000400", ibuf_valid, ibuf_fault, ibuf_pc); end
        ifetch_pc = 32'h404;
        mem_req_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (ibuf_valid !== 1'b0 || ibuf_fault !== 1'b0 || ibuf_pc !== 32'h0 || ibuf_inst !== 32'h0) begin
            failures++; $display("FAIL rst_mid_ibuf got=%0h/%0h/%h/%h exp=0/0/0/0", ibuf_valid, ibuf_fault, ibuf_pc, ibuf_inst); end
        checks++; if (mem_req_valid !== 1'b0 || ifetch_req !== 1'b0) begin failures++; $display("FAIL rst_mid_req got=%0h/%0h exp=0/0", mem_req_valid, ifetch_req); end
        mem_req_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_backpressure();
        test_flush_no_rsp();
        test_flush_with_rsp();
        test_fault_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
